// File: rtl/transmissao_medidas_n.sv
// Serialises N_CANAIS masked measurement words as an ASCII hex frame on an 8N1 UART line.
// Latency: B*(10*DIV_BAUD+1)+1 cycles from the accepting edge to the pronto pulse.
// Backpressure: none; start requests arriving while ocupado=1 are dropped, not queued.
module transmissao_medidas_n #(
   parameter int          N_CANAIS   = 2,
   parameter int          LARGURA    = 16,
   parameter int          DIV_BAUD   = 434,
   parameter logic [7:0]  SEPARADOR  = 8'h2C,
   parameter logic [7:0]  TERMINADOR = 8'h0A
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N_CANAIS*LARGURA-1:0]  medidas,
   input  logic [N_CANAIS-1:0]          mascara,
   input  logic                         transmite,
   output logic                         tx_serial,
   output logic                         ocupado,
   output logic                         pronto
);

   localparam int D      = LARGURA / 4;
   localparam int BAUD_W = (DIV_BAUD > 1) ? $clog2(DIV_BAUD) : 1;
   localparam int DIG_W  = (D > 1) ? $clog2(D) : 1;
   localparam int IDX_W  = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      CARREGA = 3'd1,
      START   = 3'd2,
      DADOS   = 3'd3,
      STOP    = 3'd4,
      FIM     = 3'd5
   } estado_t;

   estado_t                        estado_q,  estado_d;
   logic                           trans_q,   trans_d;
   logic [N_CANAIS*LARGURA-1:0]    snap_q,    snap_d;
   // Channels still waiting to be sent; a bit clears once its last digit is loaded.
   logic [N_CANAIS-1:0]            resta_q,   resta_d;
   logic [DIG_W-1:0]               dig_q,     dig_d;
   // At least one channel has started, so later channels need a separator first.
   logic                           emitido_q, emitido_d;
   // Separator for the channel about to start has already been sent.
   logic                           sep_q,     sep_d;
   // The byte in flight is the terminator; STOP then closes the frame.
   logic                           ultimo_q,  ultimo_d;
   logic [7:0]                     byte_q,    byte_d;
   logic [BAUD_W-1:0]              baud_q,    baud_d;
   logic [2:0]                     bit_q,     bit_d;

   logic                           achou;
   logic [IDX_W-1:0]               idx;
   logic [LARGURA-1:0]             palavra;
   logic [3:0]                     nib;
   logic [7:0]                     ascii;
   logic                           fim_bit;

   // Lowest pending channel and the ASCII code of its current hex digit.
   always_comb begin
      achou = 1'b0;
      idx   = '0;
      for (int i = N_CANAIS - 1; i >= 0; i--) begin
         if (resta_q[i]) begin
            achou = 1'b1;
            idx   = IDX_W'(i);
         end
      end
      palavra = snap_q[int'(idx)*LARGURA +: LARGURA];
      nib     = palavra[4*(D-1-int'(dig_q)) +: 4];
      ascii   = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   end

   assign fim_bit = (baud_q == BAUD_W'(DIV_BAUD - 1));

   // Next-state logic: start detection, byte selection and UART bit timing.
   always_comb begin
      estado_d  = estado_q;
      trans_d   = transmite;
      snap_d    = snap_q;
      resta_d   = resta_q;
      dig_d     = dig_q;
      emitido_d = emitido_q;
      sep_d     = sep_q;
      ultimo_d  = ultimo_q;
      byte_d    = byte_q;
      baud_d    = baud_q;
      bit_d     = bit_q;

      case (estado_q)
         OCIOSO: begin
            if (transmite && !trans_q) begin
               snap_d    = medidas;
               resta_d   = mascara;
               dig_d     = '0;
               emitido_d = 1'b0;
               sep_d     = 1'b0;
               ultimo_d  = 1'b0;
               baud_d    = '0;
               bit_d     = '0;
               estado_d  = CARREGA;
            end
         end
         CARREGA: begin
            baud_d   = '0;
            bit_d    = '0;
            estado_d = START;
            if (!achou) begin
               byte_d   = TERMINADOR;
               ultimo_d = 1'b1;
            end else if (emitido_q && (dig_q == '0) && !sep_q) begin
               byte_d = SEPARADOR;
               sep_d  = 1'b1;
            end else begin
               byte_d    = ascii;
               emitido_d = 1'b1;
               sep_d     = 1'b0;
               if (dig_q == DIG_W'(D - 1)) begin
                  dig_d        = '0;
                  resta_d[idx] = 1'b0;
               end else begin
                  dig_d = dig_q + 1'b1;
               end
            end
         end
         START: begin
            baud_d = fim_bit ? '0 : baud_q + 1'b1;
            if (fim_bit) begin
               bit_d    = '0;
               estado_d = DADOS;
            end
         end
         DADOS: begin
            baud_d = fim_bit ? '0 : baud_q + 1'b1;
            if (fim_bit) begin
               if (bit_q == 3'd7) begin
                  estado_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         STOP: begin
            baud_d = fim_bit ? '0 : baud_q + 1'b1;
            if (fim_bit) begin
               estado_d = ultimo_q ? FIM : CARREGA;
            end
         end
         FIM: begin
            estado_d = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   // Outputs decoded from the registered state so reset forces them at once.
   always_comb begin
      tx_serial = 1'b1;
      case (estado_q)
         START:   tx_serial = 1'b0;
         DADOS:   tx_serial = byte_q[bit_q];
         default: tx_serial = 1'b1;
      endcase
      ocupado = (estado_q != OCIOSO);
      pronto  = (estado_q == FIM);
   end

   // State registers; reset abandons any frame in progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q  <= OCIOSO;
         trans_q   <= 1'b0;
         snap_q    <= '0;
         resta_q   <= '0;
         dig_q     <= '0;
         emitido_q <= 1'b0;
         sep_q     <= 1'b0;
         ultimo_q  <= 1'b0;
         byte_q    <= '0;
         baud_q    <= '0;
         bit_q     <= '0;
      end else begin
         estado_q  <= estado_d;
         trans_q   <= trans_d;
         snap_q    <= snap_d;
         resta_q   <= resta_d;
         dig_q     <= dig_d;
         emitido_q <= emitido_d;
         sep_q     <= sep_d;
         ultimo_q  <= ultimo_d;
         byte_q    <= byte_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
      end
   end

endmodule

// File: tb/tb_transmissao_medidas_n.sv
// Bench for transmissao_medidas_n: three instances (2x16 and 3x8 at 4 cycles/bit, 2x16 at 434).
// Expected bytes come from a string-level frame model; a UART receiver pops and compares.
// Timing, pronto/ocupado behaviour, reset abort and start filtering are checked per frame.
module tb_transmissao_medidas_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   logic [31:0] med_a;  logic [1:0] mask_a; logic trans_a;
   logic        tx_a, ocup_a, pronto_a;
   logic [23:0] med_b;  logic [2:0] mask_b; logic trans_b;
   logic        tx_b, ocup_b, pronto_b;
   logic [31:0] med_c;  logic [1:0] mask_c; logic trans_c;
   logic        tx_c, ocup_c, pronto_c;

   transmissao_medidas_n #(.N_CANAIS(2), .LARGURA(16), .DIV_BAUD(4)) u_a (
      .clock(clk), .reset(rst_n), .medidas(med_a), .mascara(mask_a),
      .transmite(trans_a), .tx_serial(tx_a), .ocupado(ocup_a), .pronto(pronto_a));

   transmissao_medidas_n #(.N_CANAIS(3), .LARGURA(8), .DIV_BAUD(4)) u_b (
      .clock(clk), .reset(rst_n), .medidas(med_b), .mascara(mask_b),
      .transmite(trans_b), .tx_serial(tx_b), .ocupado(ocup_b), .pronto(pronto_b));

   transmissao_medidas_n u_c (
      .clock(clk), .reset(rst_n), .medidas(med_c), .mascara(mask_c),
      .transmite(trans_c), .tx_serial(tx_c), .ocupado(ocup_c), .pronto(pronto_c));

   int   vectors = 0;
   int   miscompares = 0;
   byte  exp_q[$];
   int   sel = 0;
   logic tx_m, ocup_m, pronto_m;

   assign tx_m     = (sel != 0) ? tx_b     : tx_a;
   assign ocup_m   = (sel != 0) ? ocup_b   : ocup_a;
   assign pronto_m = (sel != 0) ? pronto_b : pronto_a;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // UART receiver at 4 cycles/bit, sampling mid-bit on the falling clock edge.
   initial begin : rx
      int         cnt;
      logic       busy;
      logic [9:0] bits;
      byte        e;
      busy = 1'b0;
      cnt  = 0;
      bits = '0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            busy = 1'b0;
         end else begin
            if (!busy) begin
               if (tx_m === 1'b0) begin
                  busy = 1'b1;
                  cnt  = 0;
               end
            end else begin
               cnt++;
            end
            if (busy && (cnt % 4 == 2)) begin
               bits[cnt/4] = tx_m;
               if (cnt / 4 == 9) begin
                  busy = 1'b0;
                  check("rx_framing", {bits[9], bits[0]}, 2'b10);
                  if (exp_q.size() == 0) begin
                     vectors++;
                     miscompares++;
                     $display("FAIL rx_unexpected: got %0h expected no byte", bits[8:1]);
                  end else begin
                     e = exp_q.pop_front();
                     check("rx_byte", bits[8:1], e);
                  end
               end
            end
         end
      end
   end

   // Reference frame: enabled channels as fixed-width uppercase hex, comma separated, newline ended.
   task automatic push_frame(input logic [47:0] med, input logic [2:0] mask,
                             input int n, input int l, output int nbytes);
      string       s;
      string       t;
      logic [15:0] w;
      bit          first;
      s = "";
      first = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (mask[i]) begin
            if (!first) s = {s, ","};
            first = 1'b0;
            w = 16'((med >> (i * l)) & ((48'd1 << l) - 48'd1));
            t = $sformatf("%h", w);
            t = t.toupper();
            s = {s, t.substr(4 - l / 4, 3)};
         end
      end
      s = {s, "\n"};
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      nbytes = s.len();
   endtask

   task automatic set_trans(input int dut, input logic v);
      if (dut == 0) trans_a = v; else trans_b = v;
   endtask

   // mode 0: single pulse; 1: medidas changed and a second rising edge mid-frame; 2: held 1000 cycles.
   task automatic run_frame(input int dut, input logic [47:0] med, input logic [2:0] mask, input int mode);
      int nb, lat, pulses, oerr;
      sel = dut;
      push_frame(med, mask, (dut == 0) ? 2 : 3, (dut == 0) ? 16 : 8, nb);
      @(negedge clk);
      if (dut == 0) begin med_a = med[31:0]; mask_a = mask[1:0]; end
      else          begin med_b = med[23:0]; mask_b = mask;      end
      set_trans(dut, 1'b1);
      @(posedge clk);
      #1;
      check("ocupado_at_accept", ocup_m, 1'b1);
      lat = -1; pulses = 0; oerr = 0;
      for (int k = 1; k <= 20000; k++) begin
         @(negedge clk);
         if (pronto_m === 1'b1) begin
            pulses++;
            if (lat < 0) lat = k;
         end
         if ((lat < 0) || (k == lat)) begin
            if (ocup_m !== 1'b1) oerr++;
         end else begin
            if (ocup_m !== 1'b0) oerr++;
         end
         if ((mode != 2) && (k == 1)) set_trans(dut, 1'b0);
         if ((mode == 2) && (k == 1000)) set_trans(dut, 1'b0);
         if ((mode == 1) && (k == 50)) begin
            if (dut == 0) med_a = ~med_a; else med_b = ~med_b;
         end
         if ((mode == 1) && (k == 100)) set_trans(dut, 1'b1);
         if ((mode == 1) && (k == 103)) set_trans(dut, 1'b0);
         if ((lat > 0) && (k >= lat + 20) && (k >= ((mode == 2) ? 1010 : 0))) break;
      end
      check("pronto_latency", lat, nb * (10 * 4 + 1) + 1);
      check("pronto_pulses", pulses, 1);
      check("ocupado_profile", oerr, 0);
      check("bytes_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin : stim
      logic [47:0] rm;
      logic [9:0]  fb;
      int          nb, errs;
      rst_n = 1'b0;
      med_a = '0; mask_a = '0; trans_a = 1'b0;
      med_b = '0; mask_b = '0; trans_b = 1'b0;
      med_c = 32'h1234_ABCD; mask_c = 2'b00; trans_c = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx", {tx_a, tx_b, tx_c}, 3'b111);
      check("reset_ocupado", {ocup_a, ocup_b, ocup_c}, 3'b000);
      check("reset_pronto", {pronto_a, pronto_b, pronto_c}, 3'b000);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Directed frames.
      run_frame(0, {16'h0, 16'h095E, 16'h1524}, 3'b011, 0);
      run_frame(0, {16'h0, 16'h095E, 16'h1524}, 3'b010, 0);
      run_frame(0, {16'h0, 16'h095E, 16'h1524}, 3'b000, 0);
      run_frame(1, {24'h0, 8'hFF, 8'h00, 8'hA7}, 3'b101, 0);
      run_frame(0, {16'h0, 16'hBEEF, 16'h0C40}, 3'b011, 1);
      run_frame(0, {16'h0, 16'h7F00, 16'hD00D}, 3'b001, 2);
      run_frame(1, {24'h0, 8'h3C, 8'h9B, 8'h5E}, 3'b011, 1);

      // Randomised frames.
      for (int r = 0; r < 5; r++) begin
         rm = {$urandom, $urandom};
         run_frame(0, rm, 3'($urandom_range(0, 3)), 0);
      end
      for (int r = 0; r < 4; r++) begin
         rm = {$urandom, $urandom};
         run_frame(1, rm, 3'($urandom_range(0, 7)), 0);
      end

      // Reset during the data bits of the third byte of a 2-channel frame.
      sel = 0;
      push_frame({16'h0, 16'h095E, 16'h1524}, 3'b011, 2, 16, nb);
      @(negedge clk);
      med_a = 32'h095E_1524; mask_a = 2'b11; trans_a = 1'b1;
      for (int k = 0; k < 97; k++) begin
         @(negedge clk);
         trans_a = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("reset_mid_tx", tx_a, 1'b1);
      check("reset_mid_ocupado", ocup_a, 1'b0);
      check("reset_mid_pronto", pronto_a, 1'b0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      errs = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if ((pronto_a !== 1'b0) || (ocup_a !== 1'b0) || (tx_a !== 1'b1)) errs++;
      end
      check("after_reset_idle", errs, 0);
      run_frame(0, {16'h0, 16'h095E, 16'h1524}, 3'b011, 0);

      // Bit timing at 434 cycles/bit: mascara=0 sends only 0x0A.
      @(negedge clk);
      trans_c = 1'b1;
      @(negedge clk);
      trans_c = 1'b0;
      for (int w = 0; (w < 200) && (tx_c !== 1'b0); w++) @(negedge clk);
      check("c_start_seen", tx_c, 1'b0);
      fb = {1'b1, 8'h0A, 1'b0};
      errs = 0;
      for (int j = 0; j < 4340; j++) begin
         if (j > 0) @(negedge clk);
         if (tx_c !== fb[j / 434]) errs++;
      end
      check("c_bit_timing", errs, 0);
      @(negedge clk);
      check("c_fim", {pronto_c, ocup_c, tx_c}, 3'b111);
      @(negedge clk);
      check("c_idle", {pronto_c, ocup_c, tx_c}, 3'b001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
